// File: rtl/gate_response_checker.sv
// Self-checking response reader for the four-input gate lab: walks all 16 vectors,
// samples {g,f,e} after SETTLE cycles and accumulates error count, mask and first failure.
module gate_response_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [2:0] fail_mask,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_APPLY  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    logic [1:0] r_state;
    logic [3:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [4:0] r_err_cnt;
    logic [2:0] r_fail_mask;
    logic [3:0] r_first_vec;
    logic       r_first_valid;

    logic [2:0] w_expect;
    logic [2:0] w_mismatch;
    logic       w_any;
    logic [4:0] w_err_next;

    assign w_expect   = {&r_idx, r_idx[3] & r_idx[2], r_idx[1] & r_idx[0]};
    assign w_mismatch = {g, f, e} ^ w_expect;
    assign w_any      = |w_mismatch;
    assign w_err_next = r_err_cnt + 5'(w_any);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_cnt     <= '0;
            r_fail_mask   <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_APPLY;
                        r_idx         <= '0;
                        r_cnt         <= '0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_err_cnt     <= '0;
                        r_fail_mask   <= '0;
                        r_first_vec   <= '0;
                        r_first_valid <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (w_any) begin
                        r_err_cnt   <= w_err_next;
                        r_fail_mask <= r_fail_mask | w_mismatch;
                        if (!r_first_valid) begin
                            r_first_vec   <= r_idx;
                            r_first_valid <= 1'b1;
                        end
                    end
                    // idx stays at 15 in DONE, which is what drives 4'hF onto the vector.
                    if (r_idx == 4'hF) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 5'd0);
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_cnt   <= '0;
                        r_state <= S_APPLY;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign a                = r_idx[0];
    assign b                = r_idx[1];
    assign c                = r_idx[2];
    assign d                = r_idx[3];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_cnt          = r_err_cnt;
    assign fail_mask        = r_fail_mask;
    assign first_fail_vec   = r_first_vec;
    assign first_fail_valid = r_first_valid;

endmodule
